// File: rtl/gen3_scr_pkg.sv
// Shared constants for the Gen3 128b/130b scrambler: the G(X) tap mask, the per-lane seeds,
// the beat mode encoding and the single-step Galois LFSR function.
package gen3_scr_pkg;

    localparam int unsigned LFSR_W = 23;

    // Taps for X^21, X^16, X^8, X^5, X^2 and 1, fed back from state[22] in Galois form.
    localparam logic [LFSR_W-1:0] SCR_TAPS = 23'h210125;

    typedef enum logic [1:0] {
        SCR_MODE_SCRAMBLE    = 2'b00,
        SCR_MODE_BYPASS_ADV  = 2'b01,
        SCR_MODE_BYPASS_HOLD = 2'b10,
        SCR_MODE_HOLD        = 2'b11
    } scr_mode_e;

    function automatic logic [LFSR_W-1:0] scr_seed(input int unsigned idx);
        logic [2:0] sel;
        sel = 3'(idx % 8);
        case (sel)
            3'd0:    return 23'h1DBFBC;
            3'd1:    return 23'h0607BB;
            3'd2:    return 23'h1EC760;
            3'd3:    return 23'h18C0DB;
            3'd4:    return 23'h010F12;
            3'd5:    return 23'h19CFC9;
            3'd6:    return 23'h0277CE;
            default: return 23'h1BB807;
        endcase
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? SCR_TAPS : '0);
    endfunction

endpackage

// File: rtl/gen3_scr_lane.sv
// One lane's 23-bit scrambler LFSR: exposes the DW-bit key for the current beat and
// advances, holds or reloads its seed under control of the shared beat decode.
module gen3_scr_lane
    import gen3_scr_pkg::*;
#(
    parameter int unsigned       DW   = 8,
    parameter logic [LFSR_W-1:0] SEED = 23'h1DBFBC
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          i_scr_reset,
    input  logic          i_valid,
    input  logic          i_advance,
    input  logic          i_reload,
    output logic [DW-1:0] o_key_c
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;

    // Unrolled bit-serial walk: key bit k is the MSB before the k-th step.
    always_comb begin
        w_lfsr_next = r_lfsr;
        o_key_c     = '0;
        for (int k = 0; k < int'(DW); k++) begin
            o_key_c[k]  = w_lfsr_next[LFSR_W-1];
            w_lfsr_next = lfsr_step(w_lfsr_next);
        end
    end

    // Reload beats take the seed even when the same beat also asked to advance.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= SEED;
        end else if (i_scr_reset || (i_valid && i_reload)) begin
            r_lfsr <= SEED;
        end else if (i_valid && i_advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end

endmodule

// File: rtl/gen3_multilane_scrambler.sv
// Multi-lane 128b/130b scrambler between the block framer and the PIPE lanes: per-lane
// LFSRs with shared mode/reload control, one-cycle registered datapath and block alignment check.
module gen3_multilane_scrambler
    import gen3_scr_pkg::*;
#(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                        pclk,
    input  logic                        reset_n,
    input  logic                        scr_reset,
    input  logic                        in_valid,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    input  logic                        in_block_start,
    input  logic [1:0]                  in_sync_hdr,
    input  logic [1:0]                  in_mode,
    input  logic                        in_seed_reload,
    output logic                        out_valid,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_block_start,
    output logic [1:0]                  out_sync_hdr,
    output logic                        out_align_err
);

    localparam int unsigned BEATS     = 128 / DATA_WIDTH;
    localparam int unsigned CNT_W     = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [LANES*DATA_WIDTH-1:0] w_key;
    logic [LANES*DATA_WIDTH-1:0] w_data_nxt;
    logic                        w_advance;
    logic                        w_scramble;
    logic [CNT_W-1:0]            r_beat_cnt;

    assign w_scramble = (in_mode == SCR_MODE_SCRAMBLE);
    assign w_advance  = w_scramble || (in_mode == SCR_MODE_BYPASS_ADV);
    // A beat coinciding with scr_reset goes out unscrambled.
    assign w_data_nxt = (w_scramble && !scr_reset) ? (in_data ^ w_key) : in_data;

    for (genvar n = 0; n < int'(LANES); n++) begin : g_lane
        gen3_scr_lane #(
            .DW   (DATA_WIDTH),
            .SEED (scr_seed(n))
        ) u_lane (
            .pclk        (pclk),
            .reset_n     (reset_n),
            .i_scr_reset (scr_reset),
            .i_valid     (in_valid),
            .i_advance   (w_advance),
            .i_reload    (in_seed_reload),
            .o_key_c     (w_key[n*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Output registers, beat counter and the mid-block block_start check.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_block_start <= 1'b0;
            out_sync_hdr    <= 2'b00;
            out_align_err   <= 1'b0;
            r_beat_cnt      <= '0;
        end else begin
            out_valid       <= in_valid;
            out_block_start <= in_valid && in_block_start;
            out_align_err   <= 1'b0;
            if (in_valid) begin
                out_data <= w_data_nxt;
            end
            if (in_valid && in_block_start) begin
                out_sync_hdr <= in_sync_hdr;
            end
            if (scr_reset) begin
                r_beat_cnt <= '0;
            end else if (in_valid) begin
                if (in_block_start && (r_beat_cnt != '0)) begin
                    out_align_err <= 1'b1;
                    r_beat_cnt    <= CNT_W'(1);
                end else if (r_beat_cnt == LAST_BEAT) begin
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gen3_multilane_scrambler.sv
// Self-checking bench for gen3_multilane_scrambler (4 lanes x 8 bits) against a bit-serial
// model of G(X) with per-lane key streams, block position and expected output registers.
module tb_gen3_multilane_scrambler;

    localparam int LANES = 4;
    localparam int DW    = 8;

    logic        pclk = 1'b0;
    logic        reset_n;
    logic        scr_reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_block_start;
    logic [1:0]  in_sync_hdr;
    logic [1:0]  in_mode;
    logic        in_seed_reload;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_block_start;
    logic [1:0]  out_sync_hdr;
    logic        out_align_err;

    always #5 pclk = ~pclk;

    gen3_multilane_scrambler #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
        .pclk            (pclk),
        .reset_n         (reset_n),
        .scr_reset       (scr_reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_block_start  (in_block_start),
        .in_sync_hdr     (in_sync_hdr),
        .in_mode         (in_mode),
        .in_seed_reload  (in_seed_reload),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_block_start (out_block_start),
        .out_sync_hdr    (out_sync_hdr),
        .out_align_err   (out_align_err)
    );

    int unsigned seeds [8] = '{32'h1DBFBC, 32'h0607BB, 32'h1EC760, 32'h18C0DB,
                               32'h010F12, 32'h19CFC9, 32'h0277CE, 32'h1BB807};

    int unsigned m_lfsr [LANES];
    int          m_cnt;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_bs;
    logic [1:0]  exp_hdr;
    logic        exp_err;
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    // Next 8 key bits of G(X) from state s_in, bit-serially: key = coefficient of X^22.
    function automatic logic [7:0] keystream(input int unsigned s_in, output int unsigned s_out);
        int unsigned s;
        logic [7:0]  k;
        s = s_in;
        for (int i = 0; i < 8; i++) begin
            k[i] = s[22];
            s    = (s << 1) & 32'h7FFFFF;
            if (k[i]) s = s ^ 32'h210125;
        end
        s_out = s;
        return k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < LANES; n++) m_lfsr[n] = seeds[n % 8];
        m_cnt     = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_bs    = 1'b0;
        exp_hdr   = 2'b00;
        exp_err   = 1'b0;
    endtask

    task automatic model_beat(input bit v, input logic [31:0] d, input bit bs, input logic [1:0] hdr,
                              input logic [1:0] mode, input bit rl, input bit sr);
        int unsigned nxt;
        logic [7:0]  key;
        exp_valid = v;
        exp_bs    = v && bs;
        exp_err   = 1'b0;
        if (v && bs) exp_hdr = hdr;
        for (int n = 0; n < LANES; n++) begin
            key = keystream(m_lfsr[n], nxt);
            if (v) exp_data[n*8 +: 8] = (mode == 2'b00 && !sr) ? (d[n*8 +: 8] ^ key) : d[n*8 +: 8];
            if (sr || (v && rl))          m_lfsr[n] = seeds[n % 8];
            else if (v && mode < 2'b10)   m_lfsr[n] = nxt;
        end
        if (sr) m_cnt = 0;
        else if (v) begin
            if (bs && m_cnt != 0) begin
                exp_err = 1'b1;
                m_cnt   = 1;
            end else begin
                m_cnt = (m_cnt + 1) % (128 / DW);
            end
        end
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit bs, input logic [1:0] hdr,
                        input logic [1:0] mode, input bit rl, input bit sr);
        in_valid       = v;
        in_data        = d;
        in_block_start = bs;
        in_sync_hdr    = hdr;
        in_mode        = mode;
        in_seed_reload = rl;
        scr_reset      = sr;
        model_beat(v, d, bs, hdr, mode, rl, sr);
        @(posedge pclk);
        #3;
    endtask

    task automatic beat(input logic [7:0] b, input logic [1:0] mode, input bit rl);
        step(1'b1, {4{b}}, (m_cnt == 0), 2'b01, mode, rl, 1'b0);
    endtask

    // Every cycle, compare all outputs against the model's expected registers.
    always @(posedge pclk) begin
        #1;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("out_data", out_data, exp_data);
            chk("out_block_start", 32'(out_block_start), 32'(exp_bs));
            chk("out_sync_hdr", 32'(out_sync_hdr), 32'(exp_hdr));
            chk("out_align_err", 32'(out_align_err), 32'(exp_err));
        end
    end

    initial begin
        int unsigned tmp;
        logic [7:0]  l [LANES];
        reset_n        = 1'b0;
        scr_reset      = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        in_block_start = 1'b0;
        in_sync_hdr    = 2'b00;
        in_mode        = 2'b00;
        in_seed_reload = 1'b0;
        model_reset();
        chk("model_seed0_key0", 32'(keystream(seeds[0], tmp)), 32'h6C);
        repeat (2) @(posedge pclk);
        #3;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_err", 32'(out_align_err), 0);

        // Key stream of zeros: lane 0 first byte and distinct lanes.
        beat(8'h00, 2'b00, 1'b0);
        chk("lane0_key0", 32'(out_data[7:0]), 32'h6C);
        for (int n = 0; n < LANES; n++) l[n] = out_data[n*8 +: 8];
        chk("lanes_differ", 32'((l[0] != l[1]) && (l[0] != l[2]) && (l[0] != l[3]) &&
                                (l[1] != l[2]) && (l[1] != l[3]) && (l[2] != l[3])), 1);
        for (int i = 1; i < 16; i++) beat(8'h00, 2'b00, 1'b0);

        // Scramble, hold x4, scramble.
        step(1'b1, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1);
        beat(8'hA5, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            beat(8'hA5, (i % 2 == 0) ? 2'b10 : 2'b11, 1'b0);
            chk("hold_passthru", out_data, 32'hA5A5A5A5);
        end
        beat(8'hA5, 2'b00, 1'b0);

        // Bypass-advance x2, then scramble.
        beat(8'h3C, 2'b01, 1'b0);
        chk("bypass_adv_passthru", out_data, 32'h3C3C3C3C);
        beat(8'h3C, 2'b01, 1'b0);
        beat(8'h00, 2'b00, 1'b0);

        // Seed reload on beat 7: beat 8 restarts the key stream.
        step(1'b1, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) beat(8'h00, 2'b00, 1'b0);
        beat(8'h00, 2'b00, 1'b1);
        beat(8'h00, 2'b00, 1'b0);
        chk("reload_lane0_key0", 32'(out_data[7:0]), 32'h6C);

        // Misaligned block_start at beat 5, then a correctly aligned one.
        step(1'b1, 32'h0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) beat(8'h11, 2'b00, 1'b0);
        step(1'b1, $urandom, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
        chk("align_err_pulse", 32'(out_align_err), 1);
        beat(8'h22, 2'b00, 1'b0);
        chk("align_err_one_cycle", 32'(out_align_err), 0);
        for (int i = 0; i < 14; i++) beat(8'h33, 2'b00, 1'b0);
        step(1'b1, $urandom, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0);
        chk("aligned_no_err", 32'(out_align_err), 0);

        // Asynchronous reset mid-block.
        for (int i = 0; i < 3; i++) beat(8'h44, 2'b00, 1'b0);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        chk("async_reset_data", out_data, 0);
        chk("async_reset_valid", 32'(out_valid), 0);
        @(posedge pclk);
        #3;
        reset_n = 1'b1;
        beat(8'h00, 2'b00, 1'b0);
        chk("post_reset_lane0_key0", 32'(out_data[7:0]), 32'h6C);

        // scr_reset with a valid beat: bypassed, seeds restored.
        for (int i = 0; i < 4; i++) beat(8'h55, 2'b00, 1'b0);
        step(1'b1, 32'h5A5A5A5A, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1);
        chk("scr_reset_bypass", out_data, 32'h5A5A5A5A);
        chk("scr_reset_valid", 32'(out_valid), 1);
        beat(8'h00, 2'b00, 1'b0);
        chk("scr_reset_lane0_key0", 32'(out_data[7:0]), 32'h6C);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bit v, bs, rl, sr;
            v  = ($urandom_range(0, 9) < 8);
            bs = ($urandom_range(0, 19) == 0) ? 1'b1 : (m_cnt == 0);
            rl = ($urandom_range(0, 29) == 0);
            sr = ($urandom_range(0, 59) == 0);
            step(v, $urandom, bs, 2'($urandom), 2'($urandom_range(0, 3)), rl, sr);
        end
        step(1'b0, 32'h0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
